// File: rtl/tribus_if.sv
// Bus bundle between the four requesters and the tribus_arbiter master stage.
// master: arbiter side (drives grant and bus word); slave: requester/bus side.
interface tribus_if;
    logic [3:0] req;
    logic [3:0] wr;
    logic [6:0] addr0;
    logic [6:0] addr1;
    logic [6:0] addr2;
    logic [6:0] addr3;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [7:0] wdata2;
    logic [7:0] wdata3;
    logic [3:0] gnt;
    logic       bus_en;
    logic [2:0] ENA;
    logic [6:0] addr;
    logic [7:0] writedata;
    logic       busy;

    modport master (
        input  req, wr, addr0, addr1, addr2, addr3,
        input  wdata0, wdata1, wdata2, wdata3,
        output gnt, bus_en, ENA, addr, writedata, busy
    );

    modport slave (
        output req, wr, addr0, addr1, addr2, addr3,
        output wdata0, wdata1, wdata2, wdata3,
        input  gnt, bus_en, ENA, addr, writedata, busy
    );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin master stage for triBUS4 with a mandatory turnaround gap between owners.
// Optional macro ARB_TIMEOUT_EN: revoke an owner after MAX_TENURE grant cycles when others wait.
module tribus_arbiter #(
    parameter int TURNAROUND = 1,
    parameter int MAX_TENURE = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    tribus_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] rr_reg, rr_next;
    logic [1:0] owner_reg, owner_next;
    logic [2:0] turn_cnt_reg, turn_cnt_next;
    logic [3:0] gnt_reg, gnt_next;
    logic       bus_en_reg, bus_en_next;
    logic [2:0] ena_reg, ena_next;
    logic [6:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       busy_reg, busy_next;

    logic [6:0] src_addr [4];
    logic [7:0] src_wdata [4];
    logic       hit;
    logic [1:0] pick;
    logic       expire;

    generate
        if (TURNAROUND < 1 || TURNAROUND > 7) begin : g_bad_turnaround
            $error("tribus_arbiter: TURNAROUND out of range 1..7");
        end
        if (MAX_TENURE < 2 || MAX_TENURE > 255) begin : g_bad_tenure
            $error("tribus_arbiter: MAX_TENURE out of range 2..255");
        end
    endgenerate

    assign src_addr[0]  = bus.addr0;
    assign src_addr[1]  = bus.addr1;
    assign src_addr[2]  = bus.addr2;
    assign src_addr[3]  = bus.addr3;
    assign src_wdata[0] = bus.wdata0;
    assign src_wdata[1] = bus.wdata1;
    assign src_wdata[2] = bus.wdata2;
    assign src_wdata[3] = bus.wdata3;

    // Scan from the farthest offset down so the source nearest the pointer wins.
    always_comb begin
        hit  = 1'b0;
        pick = rr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[rr_reg + 2'(i)]) begin
                hit  = 1'b1;
                pick = rr_reg + 2'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tenure_reg;
    logic [7:0] tenure_inc;

    // Counts grant cycles including the current one, saturating at MAX_TENURE.
    assign tenure_inc = (tenure_reg == 8'(MAX_TENURE)) ? tenure_reg : tenure_reg + 8'd1;
    assign expire     = (tenure_inc == 8'(MAX_TENURE)) && (|(bus.req & ~gnt_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tenure_reg <= '0;
        end else if (state_reg == GRANT) begin
            tenure_reg <= tenure_inc;
        end else begin
            tenure_reg <= '0;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        rr_next       = rr_reg;
        owner_next    = owner_reg;
        turn_cnt_next = turn_cnt_reg;
        gnt_next      = '0;
        bus_en_next   = 1'b0;
        ena_next      = '0;
        addr_next     = '0;
        wdata_next    = '0;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    state_next  = GRANT;
                    owner_next  = pick;
                    gnt_next    = 4'b0001 << pick;
                    bus_en_next = 1'b1;
                    ena_next    = {bus.wr[pick], pick};
                    addr_next   = src_addr[pick];
                    wdata_next  = src_wdata[pick];
                end
            end
            GRANT: begin
                if (!bus.req[owner_reg] || expire) begin
                    state_next    = TURN;
                    rr_next       = owner_reg + 2'd1;
                    turn_cnt_next = '0;
                end else begin
                    gnt_next    = gnt_reg;
                    bus_en_next = 1'b1;
                    ena_next    = {bus.wr[owner_reg], owner_reg};
                    addr_next   = src_addr[owner_reg];
                    wdata_next  = src_wdata[owner_reg];
                end
            end
            TURN: begin
                if (turn_cnt_reg == 3'(TURNAROUND - 1)) begin
                    state_next = IDLE;
                end else begin
                    turn_cnt_next = turn_cnt_reg + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_reg       <= '0;
            owner_reg    <= '0;
            turn_cnt_reg <= '0;
            gnt_reg      <= '0;
            bus_en_reg   <= 1'b0;
            ena_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_reg       <= rr_next;
            owner_reg    <= owner_next;
            turn_cnt_reg <= turn_cnt_next;
            gnt_reg      <= gnt_next;
            bus_en_reg   <= bus_en_next;
            ena_reg      <= ena_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            busy_reg     <= busy_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.bus_en    = bus_en_reg;
    assign bus.ENA       = ena_reg;
    assign bus.addr      = addr_reg;
    assign bus.writedata = wdata_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: two instances (TURNAROUND 1 and 3) share one stimulus
// stream and are compared every cycle against a tenure/cooldown reference model.
module tb_tribus_arbiter;
    localparam int MAXT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tribus_if bus_a ();
    tribus_if bus_b ();

    assign bus_b.req    = bus_a.req;
    assign bus_b.wr     = bus_a.wr;
    assign bus_b.addr0  = bus_a.addr0;
    assign bus_b.addr1  = bus_a.addr1;
    assign bus_b.addr2  = bus_a.addr2;
    assign bus_b.addr3  = bus_a.addr3;
    assign bus_b.wdata0 = bus_a.wdata0;
    assign bus_b.wdata1 = bus_a.wdata1;
    assign bus_b.wdata2 = bus_a.wdata2;
    assign bus_b.wdata3 = bus_a.wdata3;

    tribus_arbiter #(.TURNAROUND(1), .MAX_TENURE(MAXT)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    tribus_arbiter #(.TURNAROUND(3), .MAX_TENURE(MAXT)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, how many cooldown cycles remain, where the search starts.
    int         ta [2] = '{1, 3};
    int         m_owner [2];
    int         m_cool [2];
    int         m_rr [2];
    int         m_held [2];
    logic       m_wr [2];
    logic [6:0] m_addr [2];
    logic [7:0] m_wd [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] src_addr(int s);
        case (s)
            0: return bus_a.addr0;
            1: return bus_a.addr1;
            2: return bus_a.addr2;
            default: return bus_a.addr3;
        endcase
    endfunction

    function automatic logic [7:0] src_wd(int s);
        case (s)
            0: return bus_a.wdata0;
            1: return bus_a.wdata1;
            2: return bus_a.wdata2;
            default: return bus_a.wdata3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_cool[k] = 0; m_rr[k] = 0; m_held[k] = 0;
            m_wr[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
        end
    endtask

    task automatic model_edge(int k);
        logic [3:0] rq;
        logic [3:0] wq;
        int         o;
        bit         rel;
        rq = bus_a.req;
        wq = bus_a.wr;
        o  = m_owner[k];
        if (o >= 0) begin
            rel = (rq[o] == 1'b0);
`ifdef ARB_TIMEOUT_EN
            if (m_held[k] >= MAXT && (rq & ~(4'b0001 << o)) != 4'b0000) rel = 1'b1;
`endif
            if (rel) begin
                m_owner[k] = -1;
                m_rr[k]    = (o + 1) % 4;
                m_cool[k]  = ta[k];
            end else begin
                if (m_held[k] < MAXT) m_held[k]++;
                m_wr[k] = wq[o]; m_addr[k] = src_addr(o); m_wd[k] = src_wd(o);
            end
        end else if (m_cool[k] > 0) begin
            m_cool[k]--;
        end else begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = (m_rr[k] + j) % 4;
                if (m_owner[k] < 0 && rq[s]) begin
                    m_owner[k] = s;
                    m_held[k]  = 1;
                    m_wr[k] = wq[s]; m_addr[k] = src_addr(s); m_wd[k] = src_wd(s);
                end
            end
        end
    endtask

    task automatic check_inst(string nm, int k, logic [3:0] g, logic be, logic [2:0] en,
                              logic [6:0] ad, logic [7:0] wd, logic bz);
        logic [3:0] eg;
        logic [2:0] een;
        eg  = '0;
        een = '0;
        if (m_owner[k] >= 0) begin
            eg  = 4'b0001 << m_owner[k];
            een = {m_wr[k], 2'(m_owner[k])};
        end
        chk({nm, "_gnt"}, 32'(g), 32'(eg));
        chk({nm, "_bus_en"}, 32'(be), 32'(m_owner[k] >= 0));
        chk({nm, "_ENA"}, 32'(en), 32'(een));
        chk({nm, "_addr"}, 32'(ad), (m_owner[k] >= 0) ? 32'(m_addr[k]) : 32'd0);
        chk({nm, "_writedata"}, 32'(wd), (m_owner[k] >= 0) ? 32'(m_wd[k]) : 32'd0);
        chk({nm, "_busy"}, 32'(bz), 32'(m_owner[k] >= 0 || m_cool[k] > 0));
    endtask

    task automatic check_all();
        check_inst("a", 0, bus_a.gnt, bus_a.bus_en, bus_a.ENA, bus_a.addr, bus_a.writedata, bus_a.busy);
        check_inst("b", 1, bus_b.gnt, bus_b.bus_en, bus_b.ENA, bus_b.addr, bus_b.writedata, bus_b.busy);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
        $display("t=%0t req=%b gnt_a=%b en_a=%b ENA_a=%b gnt_b=%b en_b=%b busy_b=%b",
                 $time, bus_a.req, bus_a.gnt, bus_a.bus_en, bus_a.ENA,
                 bus_b.gnt, bus_b.bus_en, bus_b.busy);
    endtask

    initial begin
        int cnt_a, cnt_b, t, gap, o;
        int order[$];
        int exp_order [5] = '{0, 1, 2, 3, 0};

        bus_a.req = '0; bus_a.wr = '0;
        bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.addr2 = '0; bus_a.addr3 = '0;
        bus_a.wdata0 = '0; bus_a.wdata1 = '0; bus_a.wdata2 = '0; bus_a.wdata3 = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        step();

        // Single request, then registered address tracking.
        bus_a.req = 4'b0001; bus_a.addr0 = 7'h2f; bus_a.wdata0 = 8'h06;
        step();
        chk("single_gnt", 32'(bus_a.gnt), 32'h1);
        chk("single_addr", 32'(bus_a.addr), 32'h2f);
        chk("single_wdata", 32'(bus_a.writedata), 32'h06);
        bus_a.addr0 = 7'h32;
        step();
        chk("track_addr", 32'(bus_a.addr), 32'h32);

        // Turnaround length seen by each instance.
        bus_a.req = 4'b0000;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_a.busy && !bus_a.bus_en) cnt_a++;
            if (bus_b.busy && !bus_b.bus_en) cnt_b++;
        end
        chk("turn_len_a", 32'(cnt_a), 32'd1);
        chk("turn_len_b", 32'(cnt_b), 32'd3);

        // Write encoding on source 2.
        bus_a.req = 4'b0100; bus_a.wr = 4'b0100; bus_a.addr2 = 7'h10; bus_a.wdata2 = 8'hA5;
        step();
        chk("wr_ENA", 32'(bus_a.ENA), 32'b110);
        chk("wr_addr", 32'(bus_a.addr), 32'h10);
        chk("wr_wdata", 32'(bus_a.writedata), 32'hA5);
        bus_a.req = 4'b0000; bus_a.wr = 4'b0000;
        for (int i = 0; i < 6; i++) step();

        // Asynchronous reset while source 1 owns the bus.
        bus_a.req = 4'b0010; bus_a.addr1 = 7'h55; bus_a.wdata1 = 8'h3c;
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_gnt", 32'(bus_a.gnt), 32'h0);
        chk("arst_addr", 32'(bus_a.addr), 32'h0);
        bus_a.req = 4'b1010;
        #2 rst_n = 1'b1;
        step();
        chk("arst_first_gnt", 32'(bus_a.gnt), 32'b0010);

        // Clean restart, then round-robin with every source requesting.
        bus_a.req = 4'b0000;
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        bus_a.req = 4'b1111;
        t = 0;
        while (bus_a.gnt == 4'b0000 && t < 10) begin
            step();
            t++;
        end
        chk("rr_first_grant_seen", 32'(bus_a.gnt != 4'b0000), 32'd1);
        for (int n = 0; n < 5; n++) begin
            o = 0;
            for (int j = 0; j < 4; j++) if (bus_a.gnt[j]) o = j;
            order.push_back(o);
            step();
            step();
            bus_a.req[o] = 1'b0;
            gap = 0;
            t = 0;
            while (t < 10) begin
                step();
                bus_a.req[o] = 1'b1;
                if (bus_a.bus_en) break;
                gap++;
                t++;
            end
            if (n < 4) chk("rr_gap", 32'(gap), 32'd2);
        end
        for (int n = 0; n < 5; n++) chk("rr_order", 32'(order[n]), 32'(exp_order[n]));

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < 4; j++)
                if ($urandom_range(3) == 0) bus_a.req[j] = ~bus_a.req[j];
            bus_a.wr = 4'($urandom);
            bus_a.addr0 = 7'($urandom); bus_a.addr1 = 7'($urandom);
            bus_a.addr2 = 7'($urandom); bus_a.addr3 = 7'($urandom);
            bus_a.wdata0 = 8'($urandom); bus_a.wdata1 = 8'($urandom);
            bus_a.wdata2 = 8'($urandom); bus_a.wdata3 = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
